mux_nto1_rr_reg: RTL and testbench

- Parametrised N-channel, WIDTH-bit registered multiplexer; successor to the combinational 4:1 AND-OR mux.
- Each input channel has a valid/ready handshake. The block picks one channel per cycle by either round-robin arbitration or an explicit select, then registers the result into a single-entry output stage with valid/ready.
- Sits between multiple producers and one shared consumer (bus/datapath port).

---
 rtl/mux_nto1_pkg.sv | 29 ++
 rtl/mux_nto1_rr_reg_rr_arbiter.sv | 61 ++++++
 rtl/mux_nto1_rr_reg.sv | 58 +++++
 tb/tb_mux_nto1_rr_reg.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_nto1_pkg.sv
// mux_nto1_pkg: shared defaults, mode encoding and the round-robin pick function.
package mux_nto1_pkg;
  localparam int WIDTH_DEF = 64;
  localparam int NCH_DEF = 4;
  localparam int MAX_NCH = 32;
  localparam int MAX_SEL = 5;
  typedef enum logic {MODE_RR = 1'b0, MODE_FIXED = 1'b1} mode_e;
  typedef struct packed {
    logic any;
    logic [MAX_SEL-1:0] idx;
    logic [MAX_NCH-1:0] gnt;
  } pick_t;
  // Scan n channels starting at ptr, wrapping; first valid one wins.
  function automatic pick_t rr_pick(input logic [MAX_NCH-1:0] valid, input logic [MAX_SEL-1:0] ptr, input int n);
    pick_t r;
    int c;
    r = '0;
    for (int k = 0; k < MAX_NCH; k++) begin
      c = int'(ptr) + k;
      if (c >= n) c = c - n;
      if (k < n && !r.any && c < MAX_NCH && valid[c]) begin
        r.any = 1'b1;
        r.idx = MAX_SEL'(c);
        r.gnt[c] = 1'b1;
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/mux_nto1_rr_reg_rr_arbiter.sv
// rr_arbiter: combinational grant plus registered round-robin pointer.
// MUX_PKT_LOCK_EN adds packet lock: grant sticks to a channel until its last beat.
module rr_arbiter
  import mux_nto1_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int SEL_WIDTH = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       valid,
`ifdef MUX_PKT_LOCK_EN
  input  logic [NCH-1:0]       last,
`endif
  input  mode_e                mode,
  input  logic [SEL_WIDTH-1:0] sel,
  input  logic                 fire,
  output logic [NCH-1:0]       grant,
  output logic [SEL_WIDTH-1:0] idx
);
  localparam int VW = 2 ** SEL_WIDTH;
  localparam logic [SEL_WIDTH:0] NCH_L = (SEL_WIDTH + 1)'(NCH);
  logic [SEL_WIDTH-1:0] ptr, ptr_nxt;
  logic [VW-1:0] valid_ext;
  logic [NCH-1:0] rr_valid;
  logic sel_ok;
  logic unused_rr;
  pick_t rr;
`ifdef MUX_PKT_LOCK_EN
  logic lock;
  logic [SEL_WIDTH-1:0] lock_ch;
  assign rr_valid = lock ? valid & (NCH'(1) << lock_ch) : valid;
`else
  assign rr_valid = valid;
`endif
  assign valid_ext = VW'(valid);
  assign sel_ok = ({1'b0, sel} < NCH_L) && valid_ext[sel];
  assign rr = rr_pick(MAX_NCH'(rr_valid), MAX_SEL'(ptr), NCH);
  assign unused_rr = ^rr;
  assign grant = mode == MODE_FIXED ? (sel_ok ? NCH'(1) << sel : '0) : rr.gnt[NCH-1:0];
  assign idx = mode == MODE_FIXED ? sel : rr.idx[SEL_WIDTH-1:0];
  // Explicit wrap keeps ptr inside 0..NCH-1 for non-power-of-two NCH.
  assign ptr_nxt = idx == SEL_WIDTH'(NCH - 1) ? '0 : idx + 1'b1;
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
`ifdef MUX_PKT_LOCK_EN
      lock <= 1'b0;
      lock_ch <= '0;
`endif
    end else if (fire && mode == MODE_RR) begin
`ifdef MUX_PKT_LOCK_EN
      lock <= !last[idx];
      lock_ch <= idx;
      if (last[idx]) ptr <= ptr_nxt;
`else
      ptr <= ptr_nxt;
`endif
    end
  end
endmodule

// File: rtl/mux_nto1_rr_reg.sv
// mux_nto1_rr_reg: N-channel registered mux with round-robin or fixed select.
// MUX_PKT_LOCK_EN adds in_last and per-packet grant locking in round-robin mode.
module mux_nto1_rr_reg
  import mux_nto1_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NCH = NCH_DEF,
  parameter int SEL_WIDTH = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
`ifdef MUX_PKT_LOCK_EN
  input  logic [NCH-1:0]       in_last,
`endif
  input  logic                 mode,
  input  logic [SEL_WIDTH-1:0] sel,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_WIDTH-1:0] out_chan,
  output logic                 out_valid,
  input  logic                 out_ready
);
  logic load_en, fire;
  logic [NCH-1:0] grant;
  logic [SEL_WIDTH-1:0] idx;
  assign load_en = !out_valid || out_ready;
  assign in_ready = (load_en && !rst) ? grant : '0;
  assign fire = |(in_ready & in_valid);
  rr_arbiter #(.NCH(NCH), .SEL_WIDTH(SEL_WIDTH)) u_arb (
    .clk(clk),
    .rst(rst),
    .valid(in_valid),
`ifdef MUX_PKT_LOCK_EN
    .last(in_last),
`endif
    .mode(mode_e'(mode)),
    .sel(sel),
    .fire(fire),
    .grant(grant),
    .idx(idx)
  );
  // A refill in the drain cycle overwrites the old word, so no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
      out_chan <= '0;
      out_valid <= 1'b0;
    end else if (fire) begin
      out_data <= in_data[idx*WIDTH +: WIDTH];
      out_chan <= idx;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mux_nto1_rr_reg.sv
// tb_mux_nto1_rr_reg: scoreboard bench for a 4-channel and a 3-channel instance.
module tb_mux_nto1_rr_reg;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  logic [255:0] d4;
  logic [3:0] v4, r4;
  logic m4, ov4, or4;
  logic [1:0] s4, c4;
  logic [63:0] o4;
  logic [23:0] d3;
  logic [2:0] v3, r3;
  logic m3, ov3, or3;
  logic [1:0] s3, c3;
  logic [7:0] o3;
`ifdef MUX_PKT_LOCK_EN
  logic [3:0] l4 = '0;
  logic [2:0] l3 = '1;
`endif
  int tests = 0, fails = 0;
  typedef struct {
    logic [1:0] chan;
    logic [63:0] data;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  mux_nto1_rr_reg #(.WIDTH(64), .NCH(4)) dut4 (
    .clk(clk), .rst(rst), .in_data(d4), .in_valid(v4), .in_ready(r4),
`ifdef MUX_PKT_LOCK_EN
    .in_last(l4),
`endif
    .mode(m4), .sel(s4), .out_data(o4), .out_chan(c4), .out_valid(ov4), .out_ready(or4)
  );
  mux_nto1_rr_reg #(.WIDTH(8), .NCH(3)) dut3 (
    .clk(clk), .rst(rst), .in_data(d3), .in_valid(v3), .in_ready(r3),
`ifdef MUX_PKT_LOCK_EN
    .in_last(l3),
`endif
    .mode(m3), .sel(s3), .out_data(o3), .out_chan(c3), .out_valid(ov3), .out_ready(or3)
  );

  function automatic logic [63:0] pat(input int i);
    return 64'h1111_1111_1111_1111 * 64'(i + 1);
  endfunction

  task automatic do_reset();
    sb.delete();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push(input int ch, input logic [63:0] data);
    e.chan = 2'(ch);
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    v4 = '1; v3 = '1; or4 = 1'b1; or3 = 1'b1; m4 = 1'b0; m3 = 1'b0; s4 = '0; s3 = '0;
    for (int i = 0; i < 4; i++) d4[i*64 +: 64] = pat(i);
    d3 = 24'h33_22_11;
    repeat (2) @(negedge clk);
    if (r4 !== 4'b0) begin fails++; $display("FAIL reset_in_ready4 got=%b exp=0000", r4); end
    tests++;
    if (ov4 !== 1'b0) begin fails++; $display("FAIL reset_out_valid4 got=%b exp=0", ov4); end
    tests++;
    if (o4 !== 64'h0) begin fails++; $display("FAIL reset_out_data4 got=%h exp=0", o4); end
    tests++;
    if (c4 !== 2'd0) begin fails++; $display("FAIL reset_out_chan4 got=%0d exp=0", c4); end
    tests++;
    if (r3 !== 3'b0 || ov3 !== 1'b0) begin fails++; $display("FAIL reset_dut3 in_ready=%b out_valid=%b exp=000/0", r3, ov3); end
    tests++;
  endtask

  task automatic test_round_robin();
    m4 = 1'b0; v4 = 4'hF; or4 = 1'b1;
    for (int i = 0; i < 4; i++) d4[i*64 +: 64] = pat(i);
    do_reset();
    foreach (sb[i]) ;
    push(0, pat(0)); push(1, pat(1)); push(2, pat(2)); push(3, pat(3)); push(0, pat(0));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (ov4 !== 1'b1) begin fails++; $display("FAIL rr_bubble beat=%0d out_valid=%b exp=1", k, ov4); end
      tests++;
      e = sb.pop_front();
      if (c4 !== e.chan || o4 !== e.data) begin
        fails++; $display("FAIL rr_word beat=%0d got=%0d/%h exp=%0d/%h", k, c4, o4, e.chan, e.data);
      end
      tests++;
    end
  endtask

  task automatic test_fixed();
    m4 = 1'b1; s4 = 2'd2; v4 = 4'b0100; or4 = 1'b1;
    d4[128 +: 64] = 64'hDEAD_BEEF_0000_0002;
    do_reset();
    push(2, 64'hDEAD_BEEF_0000_0002);
    @(negedge clk);
    e = sb.pop_front();
    if (ov4 !== 1'b1 || c4 !== e.chan || o4 !== e.data) begin
      fails++; $display("FAIL fixed_word got=%b/%0d/%h exp=1/%0d/%h", ov4, c4, o4, e.chan, e.data);
    end
    tests++;
    v4 = 4'b0001;
    #1;
    if (r4 !== 4'b0) begin fails++; $display("FAIL fixed_no_grant in_ready=%b exp=0000", r4); end
    tests++;
    @(negedge clk);
    if (ov4 !== 1'b0) begin fails++; $display("FAIL fixed_drain out_valid=%b exp=0", ov4); end
    tests++;
    if (c4 !== 2'd2 || o4 !== 64'hDEAD_BEEF_0000_0002) begin
      fails++; $display("FAIL fixed_hold got=%0d/%h exp=2/deadbeef00000002", c4, o4);
    end
    tests++;
  endtask

  task automatic test_back_to_back();
    m4 = 1'b0; v4 = 4'hF; or4 = 1'b0;
    for (int i = 0; i < 4; i++) d4[i*64 +: 64] = pat(i);
    do_reset();
    push(0, pat(0)); push(1, pat(1));
    @(negedge clk);
    e = sb.pop_front();
    if (ov4 !== 1'b1 || c4 !== e.chan || o4 !== e.data) begin
      fails++; $display("FAIL bp_first got=%b/%0d/%h exp=1/%0d/%h", ov4, c4, o4, e.chan, e.data);
    end
    tests++;
    for (int k = 0; k < 3; k++) begin
      if (r4 !== 4'b0) begin fails++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0000", k, r4); end
      tests++;
      if (ov4 !== 1'b1 || c4 !== 2'd0 || o4 !== pat(0)) begin
        fails++; $display("FAIL bp_stable cyc=%0d got=%b/%0d/%h exp=1/0/%h", k, ov4, c4, o4, pat(0));
      end
      tests++;
      @(negedge clk);
    end
    or4 = 1'b1;
    #1;
    if (r4 !== 4'b0010) begin fails++; $display("FAIL bp_release_ready got=%b exp=0010", r4); end
    tests++;
    @(negedge clk);
    e = sb.pop_front();
    if (ov4 !== 1'b1 || c4 !== e.chan || o4 !== e.data) begin
      fails++; $display("FAIL bp_refill got=%b/%0d/%h exp=1/%0d/%h", ov4, c4, o4, e.chan, e.data);
    end
    tests++;
  endtask

  task automatic test_npot();
    m3 = 1'b0; v3 = 3'b111; or3 = 1'b1; d3 = 24'h33_22_11;
    do_reset();
    for (int k = 0; k < 6; k++) push(k % 3, 64'(8'h11 * (k % 3 + 1)));
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      e = sb.pop_front();
      if (ov3 !== 1'b1 || c3 !== e.chan || o3 !== e.data[7:0]) begin
        fails++; $display("FAIL npot_word beat=%0d got=%b/%0d/%h exp=1/%0d/%h", k, ov3, c3, o3, e.chan, e.data[7:0]);
      end
      tests++;
    end
    m3 = 1'b1; s3 = 2'd3;
    #1;
    if (r3 !== 3'b0) begin fails++; $display("FAIL npot_sel_oob in_ready=%b exp=000", r3); end
    tests++;
    @(negedge clk);
    if (ov3 !== 1'b0) begin fails++; $display("FAIL npot_sel_oob_drain out_valid=%b exp=0", ov3); end
    tests++;
  endtask

`ifdef MUX_PKT_LOCK_EN
  task automatic test_pkt_lock();
    m4 = 1'b0; v4 = 4'b0010; l4 = 4'b0000; or4 = 1'b1;
    for (int i = 0; i < 4; i++) d4[i*64 +: 64] = pat(i);
    do_reset();
    push(1, pat(1)); push(1, pat(1)); push(1, pat(1)); push(2, pat(2));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      e = sb.pop_front();
      if (ov4 !== 1'b1 || c4 !== e.chan || o4 !== e.data) begin
        fails++; $display("FAIL lock_word beat=%0d got=%b/%0d/%h exp=1/%0d/%h", k, ov4, c4, o4, e.chan, e.data);
      end
      tests++;
      v4 = 4'b0111;
      l4 = (k == 1) ? 4'b0010 : 4'b0000;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_fixed();
    test_back_to_back();
    test_npot();
`ifdef MUX_PKT_LOCK_EN
    test_pkt_lock();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
